// File: rtl/cpu_pkg.sv
// Shared types and defaults for the boot loader that sequences the core.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FLUSH = 3'd2,
    ST_RUN   = 3'd3,
    ST_HALT  = 3'd4
  } ldr_state_t;

  localparam int DEF_ADDR_W       = 5;
  localparam int DEF_FLUSH_CYCLES = 3;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Turns rising edges of the host strobe into bytes and packs them
// little-endian into 32-bit words; word_done pulses for one cycle per word.
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        full,
  input  logic        clr,
  input  logic [7:0]  data_in,
  input  logic        data_valid,
  output logic        word_done,
  output logic [31:0] word,
  output logic [1:0]  lane,
  output logic        drop
);

  logic valid_q;
  logic hit;

  // valid_q samples the strobe in every state so a level that is already
  // high when loading starts is not mistaken for a new byte.
  assign hit  = data_valid & ~valid_q & en;
  assign drop = hit & full;

  // Edge detect, lane counter and assembly register.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      lane      <= 2'd0;
      word      <= 32'd0;
      word_done <= 1'b0;
    end else begin
      valid_q   <= data_valid;
      word_done <= 1'b0;
      if (clr) begin
        lane <= 2'd0;
      end else if (hit && !full) begin
        word[{lane, 3'b000} +: 8] <= data_in;
        lane                      <= lane + 2'd1;
        if (lane == 2'd3) word_done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: writes host bytes into program memory, flushes the
// pipeline, then releases the core; re-arms on halt or a new load.
//
//   state | meaning
//   IDLE  | after reset, waiting for a load or run request
//   LOAD  | accepting host bytes, writing completed words
//   FLUSH | PC reset / pipeline clear, timed by flush_cnt
//   RUN   | core advancing
//   HALT  | core stopped by halt_req, waiting for run or load
module imem_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_mode,
  input  logic              run_req,
  input  logic [7:0]        data_in,
  input  logic              data_valid,
  input  logic              halt_req,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_flush,
  output logic              cpu_run,
  output logic [ADDR_W:0]   words_loaded,
  output logic              overflow,
  output logic              partial_err
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);

  ldr_state_t      state, state_next;
  logic [FC_W-1:0] flush_cnt;
  logic            mem_full;
  logic            load_ok;
  logic            load_entry;
  logic            load_exit;
  logic [1:0]      lane;
  logic            byte_drop;

  // words_loaded never exceeds 2^ADDR_W, so its top bit is the full flag.
  assign mem_full   = words_loaded[ADDR_W];
  assign load_ok    = (state == ST_LOAD) && load_mode;
  assign load_exit  = (state == ST_LOAD) && !load_mode;
  assign load_entry = (state != ST_LOAD) && (state_next == ST_LOAD);

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .en         (load_ok),
    .full       (mem_full),
    .clr        (load_entry | load_exit),
    .data_in    (data_in),
    .data_valid (data_valid),
    .word_done  (imem_we),
    .word       (imem_wdata),
    .lane       (lane),
    .drop       (byte_drop)
  );

  // Next-state decode; load_mode outranks halt_req, which outranks run_req.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (load_mode)    state_next = ST_LOAD;
        else if (run_req) state_next = ST_FLUSH;
      end
      ST_LOAD: begin
        if (!load_mode) state_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (load_mode)                state_next = ST_LOAD;
        else if (flush_cnt == '0)     state_next = ST_RUN;
      end
      ST_RUN: begin
        if (load_mode)     state_next = ST_LOAD;
        else if (halt_req) state_next = ST_HALT;
      end
      ST_HALT: begin
        if (load_mode)    state_next = ST_LOAD;
        else if (run_req) state_next = ST_FLUSH;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register and registered core controls.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cpu_flush <= 1'b0;
      cpu_run   <= 1'b0;
    end else begin
      state     <= state_next;
      cpu_flush <= (state_next == ST_FLUSH);
      cpu_run   <= (state_next == ST_RUN);
    end
  end

  // Flush timer: loaded on FLUSH entry, terminal count ends the flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt <= '0;
    end else if (state_next == ST_FLUSH && state != ST_FLUSH) begin
      flush_cnt <= FC_LOAD;
    end else if (flush_cnt != '0) begin
      flush_cnt <= flush_cnt - FC_W'(1);
    end
  end

  // Write address, word count and sticky load flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      imem_addr    <= '0;
      words_loaded <= '0;
      overflow     <= 1'b0;
      partial_err  <= 1'b0;
    end else if (load_entry) begin
      imem_addr    <= '0;
      words_loaded <= '0;
      overflow     <= 1'b0;
      partial_err  <= 1'b0;
    end else begin
      if (imem_we) begin
        words_loaded <= words_loaded + (ADDR_W + 1)'(1);
        // Hold at the last word instead of wrapping onto address 0.
        if (imem_addr != {ADDR_W{1'b1}}) imem_addr <= imem_addr + ADDR_W'(1);
      end
      if (byte_drop)                  overflow    <= 1'b1;
      if (load_exit && lane != 2'd0)  partial_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: cycle table for FSM control, directed load
// sequences, and randomized loads checked against a byte-stream model.
module tb_imem_loader;

  localparam int ADDR_W  = 5;
  localparam int FLUSH_N = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              load_mode = 1'b0;
  logic              run_req = 1'b0;
  logic [7:0]        data_in = 8'h00;
  logic              data_valid = 1'b0;
  logic              halt_req = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_flush;
  logic              cpu_run;
  logic [ADDR_W:0]   words_loaded;
  logic              overflow;
  logic              partial_err;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;
  wr_t wr_log[$];

  typedef struct {
    logic       lm, rr, hr, dv;
    logic [7:0] din;
    logic       e_fl, e_run, e_we;
    logic [5:0] e_wl;
    logic       e_ovf, e_perr;
  } vec_t;
  vec_t tbl[$];

  imem_loader #(.ADDR_W(ADDR_W), .FLUSH_CYCLES(FLUSH_N)) dut (
    .clk          (clk),
    .rst          (rst),
    .load_mode    (load_mode),
    .run_req      (run_req),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .halt_req     (halt_req),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_flush    (cpu_flush),
    .cpu_run      (cpu_run),
    .words_loaded (words_loaded),
    .overflow     (overflow),
    .partial_err  (partial_err)
  );

  always #5 clk = ~clk;

  // Memory-side view: every write the program memory would accept.
  always @(posedge clk) begin
    if (imem_we) wr_log.push_back(wr_t'({imem_addr, imem_wdata}));
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outs_vec();
    return {16'h0, imem_we, imem_addr, imem_wdata, cpu_flush, cpu_run,
            words_loaded, overflow, partial_err};
  endfunction

  function automatic vec_t mk(logic lm, logic rr, logic hr, logic dv, logic [7:0] din,
                              logic fl, logic run, logic we, logic [5:0] wl,
                              logic ovf, logic perr);
    vec_t v;
    v.lm = lm; v.rr = rr; v.hr = hr; v.dv = dv; v.din = din;
    v.e_fl = fl; v.e_run = run; v.e_we = we; v.e_wl = wl;
    v.e_ovf = ovf; v.e_perr = perr;
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1; load_mode = 1'b0; run_req = 1'b0; halt_req = 1'b0;
    data_valid = 1'b0; data_in = 8'h00;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int hold, input int gap);
    data_in = b; data_valid = 1'b1;
    repeat (hold) step();
    data_valid = 1'b0;
    repeat (gap) step();
  endtask

  // Called right after the edge that should start a flush.
  task automatic expect_flush(input string tag);
    int n = 0;
    chk({tag, "_flush_start"}, 64'(cpu_flush), 64'd1);
    while (cpu_flush && n < 20) begin
      if (cpu_run) chk({tag, "_run_in_flush"}, 64'(cpu_run), 64'd0);
      n++;
      step();
    end
    chk({tag, "_flush_len"}, 64'(n), 64'(FLUSH_N));
    chk({tag, "_run"}, 64'(cpu_run), 64'd1);
  endtask

  // Load a byte stream and compare against the stream-level rules:
  // word i = bytes 4i..4i+3 little-endian at address i, at most 2^ADDR_W
  // words, overflow iff more bytes than fit, partial iff a fitting stream
  // is not a whole number of words.
  task automatic load_session(input logic [7:0] bq[$], input bit rnd,
                              input bit edge_on_drop, input string tag);
    int n, cap, ew;
    logic [31:0] exp_w;
    wr_log.delete();
    load_mode = 1'b1;
    step();
    chk({tag, "_entry_flags"}, {words_loaded, overflow, partial_err, cpu_run}, 64'd0);
    foreach (bq[i]) begin
      send(bq[i], rnd ? int'($urandom_range(1, 3)) : 1, rnd ? int'($urandom_range(1, 3)) : 1);
    end
    load_mode = 1'b0;
    if (edge_on_drop) begin
      data_in = 8'hEE;
      data_valid = 1'b1;
    end
    step();
    data_valid = 1'b0;
    n   = bq.size();
    cap = 4 * (1 << ADDR_W);
    ew  = (n / 4 > (1 << ADDR_W)) ? (1 << ADDR_W) : n / 4;
    chk({tag, "_nwrites"}, 64'(wr_log.size()), 64'(ew));
    for (int i = 0; i < ew; i++) begin
      if (i < wr_log.size()) begin
        exp_w = {bq[4*i+3], bq[4*i+2], bq[4*i+1], bq[4*i]};
        chk($sformatf("%s_addr%0d", tag, i), 64'(wr_log[i].addr), 64'(i));
        chk($sformatf("%s_data%0d", tag, i), 64'(wr_log[i].data), 64'(exp_w));
      end
    end
    chk({tag, "_words_loaded"}, 64'(words_loaded), 64'(ew));
    chk({tag, "_overflow"}, 64'(overflow), 64'(n > cap));
    chk({tag, "_partial"}, 64'(partial_err), 64'((n <= cap) && (n % 4 != 0)));
    expect_flush(tag);
  endtask

  initial begin
    logic [7:0] bq[$];
    int         nlog;

    // Reset state
    do_reset();
    chk("reset_outs", outs_vec(), 64'd0);

    // Cycle table: inputs before an edge, expected outputs after it.
    //             lm rr hr dv din    fl run we wl ovf perr
    tbl.push_back(mk(0, 0, 1, 0, 8'h00, 0, 0, 0, 0, 0, 0)); // IDLE ignores halt
    tbl.push_back(mk(0, 1, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0)); // run_req -> FLUSH
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0, 0)); // RUN
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 8'h00, 0, 0, 0, 0, 0, 0)); // halt -> HALT
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0)); // HALT -> FLUSH
    tbl.push_back(mk(1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0)); // flush abandoned
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1, 0, 0, 1, 8'h5A, 0, 0, 0, 0, 0, 0)); // strobe held 5 cycles
    tbl.push_back(mk(1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 1)); // one byte -> partial
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 1, 0, 8'h00, 0, 0, 0, 0, 0, 0)); // load beats halt, flags clear
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0, 0));
    foreach (tbl[i]) begin
      load_mode = tbl[i].lm; run_req = tbl[i].rr; halt_req = tbl[i].hr;
      data_valid = tbl[i].dv; data_in = tbl[i].din;
      step();
      chk($sformatf("tbl%0d_ctl", i), {cpu_flush, cpu_run, imem_we},
          {tbl[i].e_fl, tbl[i].e_run, tbl[i].e_we});
      chk($sformatf("tbl%0d_flags", i), {words_loaded, overflow, partial_err},
          {tbl[i].e_wl, tbl[i].e_ovf, tbl[i].e_perr});
    end
    load_mode = 0; run_req = 0; halt_req = 0; data_valid = 0;

    // Two-instruction program
    do_reset();
    bq = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    load_session(bq, 1'b0, 1'b0, "prog2");
    if (wr_log.size() == 2) begin
      chk("prog2_w0", {27'd0, wr_log[0].addr, wr_log[0].data}, {27'd0, 5'd0, 32'h00A00513});
      chk("prog2_w1", {27'd0, wr_log[1].addr, wr_log[1].data}, {27'd0, 5'd1, 32'h00100593});
    end

    // Halt pulse, then restart with memory untouched
    nlog = wr_log.size();
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    chk("halt_run_off", 64'(cpu_run), 64'd0);
    step();
    chk("halt_stays", {cpu_run, cpu_flush}, 64'd0);
    run_req = 1'b1;
    step();
    run_req = 1'b0;
    expect_flush("restart");
    chk("restart_no_write", 64'(wr_log.size()), 64'(nlog));

    // Six bytes: one word plus a partial
    bq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    load_session(bq, 1'b0, 1'b0, "part6");
    chk("part6_wl", 64'(words_loaded), 64'd1);
    chk("part6_perr", 64'(partial_err), 64'd1);

    // 33 words into a 32-word memory
    bq.delete();
    for (int i = 0; i < 132; i++) bq.push_back(8'(i * 7 + 3));
    load_session(bq, 1'b0, 1'b0, "ovf");
    chk("ovf_nwrites", 64'(wr_log.size()), 64'd32);
    if (wr_log.size() > 0)
      chk("ovf_last_addr", 64'(wr_log[wr_log.size()-1].addr), 64'd31);
    chk("ovf_flag", 64'(overflow), 64'd1);

    // Reset during FLUSH
    do_reset();
    run_req = 1'b1;
    step();
    run_req = 1'b0;
    chk("rstfl_in_flush", 64'(cpu_flush), 64'd1);
    rst = 1'b1;
    step();
    chk("rstfl_outs", outs_vec(), 64'd0);
    rst = 1'b0;
    step();
    chk("rstfl_idle", {cpu_flush, cpu_run}, 64'd0);

    // Reset coinciding with the 4th byte: no write may follow
    do_reset();
    wr_log.delete();
    load_mode = 1'b1;
    step();
    send(8'h11, 1, 1);
    send(8'h22, 1, 1);
    send(8'h33, 1, 1);
    data_in = 8'h44; data_valid = 1'b1; rst = 1'b1;
    step();
    chk("rst4_outs", outs_vec(), 64'd0);
    rst = 1'b0; data_valid = 1'b0; load_mode = 1'b0;
    repeat (3) step();
    chk("rst4_no_we", 64'(wr_log.size()), 64'd0);
    chk("rst4_idle", outs_vec(), 64'd0);

    // Randomized loads against the stream model
    for (int s = 0; s < 25; s++) begin
      int n;
      n = ($urandom_range(0, 4) == 0) ? int'($urandom_range(120, 136))
                                      : int'($urandom_range(0, 24));
      bq.delete();
      repeat (n) bq.push_back(8'($urandom));
      load_session(bq, 1'b1, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", s));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
